// File: rtl/spi_txn_arbiter.sv
// Round-robin arbiter/sequencer sharing one SPI byte engine among NREQ requesters.
// Define SPI_TIMEOUT_EN to build the done_tick watchdog that aborts a stalled burst.
//
// state | meaning
// IDLE  | no owner; grant first requester at or after the rr pointer
// SETUP | ss_n low, counting SS_SETUP cycles before the first byte
// LOAD  | waiting for engine ready, then start one byte
// XFER  | byte in flight, waiting for done_tick
// HOLD  | last byte done, ss_n held low for SS_HOLD cycles
// GAP   | ss_n released, SS_GAP cycles before the next grant
module spi_txn_arbiter #(
   parameter int NREQ        = 2,
   parameter int LEN_W       = 4,
   parameter int SS_SETUP    = 4,
   parameter int SS_HOLD     = 4,
   parameter int SS_GAP      = 2,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*LEN_W-1:0] req_len,
   input  logic [NREQ-1:0]       req_cpol,
   input  logic [NREQ-1:0]       req_cpha,
   input  logic [NREQ*16-1:0]    req_dvsr,
   input  logic [NREQ*8-1:0]     tx_data,
   output logic [NREQ-1:0]       grant,
   output logic [NREQ-1:0]       tx_rd,
   output logic [7:0]            rx_data,
   output logic [NREQ-1:0]       rx_valid,
   output logic [NREQ-1:0]       txn_done,
   output logic [NREQ-1:0]       txn_err,
   output logic [NREQ-1:0]       ss_n,
   output logic                  spi_start,
   output logic [7:0]            spi_din,
   output logic [15:0]           spi_dvsr,
   output logic                  spi_cpol,
   output logic                  spi_cpha,
   input  logic                  spi_ready,
   input  logic                  spi_done_tick,
   input  logic [7:0]            spi_dout
);

   localparam int IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TMR_MAX = (SS_SETUP > SS_HOLD) ?
                            ((SS_SETUP > SS_GAP) ? SS_SETUP : SS_GAP) :
                            ((SS_HOLD > SS_GAP) ? SS_HOLD : SS_GAP);
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(SS_SETUP - 1);
   localparam logic [TMR_W-1:0] HOLD_LD  = TMR_W'(SS_HOLD - 1);
   localparam logic [TMR_W-1:0] GAP_LD   = TMR_W'(SS_GAP - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

   if (SS_SETUP < 1 || SS_HOLD < 1 || SS_GAP < 1 || TIMEOUT_CYC < 2) begin : g_bad_param
      $error("spi_txn_arbiter: SS_* must be >= 1 and TIMEOUT_CYC >= 2");
   end

   typedef enum logic [2:0] {IDLE, SETUP, LOAD, XFER, HOLD, GAP} state_t;

   state_t           state, state_nx;
   logic [IDX_W-1:0] ptr, ptr_nx;
   logic [IDX_W-1:0] idx, idx_nx;
   logic [IDX_W-1:0] pick, cand;
   logic             found;
   logic [LEN_W-1:0] byte_cnt, byte_cnt_nx;
   logic [TMR_W-1:0] tmr, tmr_nx;
   logic [NREQ-1:0]  grant_nx, ss_n_nx, rx_valid_nx, txn_done_nx;
   logic [15:0]      spi_dvsr_nx;
   logic             spi_cpol_nx, spi_cpha_nx;
   logic [7:0]       rx_data_nx;

   logic [7:0]       tx_byte  [NREQ];
   logic [LEN_W-1:0] len_field[NREQ];
   logic [15:0]      dvsr_field[NREQ];

   for (genvar g = 0; g < NREQ; g++) begin : g_split
      assign tx_byte[g]    = tx_data[g*8 +: 8];
      assign len_field[g]  = req_len[g*LEN_W +: LEN_W];
      assign dvsr_field[g] = req_dvsr[g*16 +: 16];
   end

`ifdef SPI_TIMEOUT_EN
   localparam int WDOG_W = $clog2(TIMEOUT_CYC);
   localparam logic [WDOG_W-1:0] WDOG_LD = WDOG_W'(TIMEOUT_CYC - 1);

   logic [WDOG_W-1:0] wdog, wdog_nx;
   logic [NREQ-1:0]   txn_err_nx;
`endif

   always_comb begin
      state_nx    = state;
      ptr_nx      = ptr;
      idx_nx      = idx;
      byte_cnt_nx = byte_cnt;
      tmr_nx      = tmr;
      grant_nx    = grant;
      ss_n_nx     = ss_n;
      spi_dvsr_nx = spi_dvsr;
      spi_cpol_nx = spi_cpol;
      spi_cpha_nx = spi_cpha;
      rx_data_nx  = rx_data;
      rx_valid_nx = '0;
      txn_done_nx = '0;
      spi_start   = 1'b0;
      spi_din     = '0;
      tx_rd       = '0;
      found       = 1'b0;
      pick        = '0;
      cand        = '0;
`ifdef SPI_TIMEOUT_EN
      wdog_nx     = wdog;
      txn_err_nx  = '0;
`endif
      case (state)
         IDLE: begin
            for (int k = 0; k < NREQ; k++) begin
               cand = IDX_W'((int'(ptr) + k) % NREQ);
               if (!found && req[cand]) begin
                  found = 1'b1;
                  pick  = cand;
               end
            end
            if (found) begin
               idx_nx         = pick;
               grant_nx       = '0;
               grant_nx[pick] = 1'b1;
               ss_n_nx        = ~grant_nx;
               byte_cnt_nx    = len_field[pick];
               spi_dvsr_nx    = dvsr_field[pick];
               spi_cpol_nx    = req_cpol[pick];
               spi_cpha_nx    = req_cpha[pick];
               tmr_nx         = SETUP_LD;
               state_nx       = SETUP;
            end
         end
         SETUP: begin
            if (tmr == '0) state_nx = LOAD;
            else           tmr_nx   = tmr - 1'b1;
         end
         LOAD: begin
            // start is combinational on ready so it can never fire into a busy engine
            if (spi_ready) begin
               spi_start  = 1'b1;
               spi_din    = tx_byte[idx];
               tx_rd[idx] = 1'b1;
               state_nx   = XFER;
`ifdef SPI_TIMEOUT_EN
               wdog_nx    = WDOG_LD;
`endif
            end
         end
         XFER: begin
            if (spi_done_tick) begin
               rx_data_nx       = spi_dout;
               rx_valid_nx[idx] = 1'b1;
               if (byte_cnt == '0) begin
                  tmr_nx   = HOLD_LD;
                  state_nx = HOLD;
               end else begin
                  byte_cnt_nx = byte_cnt - 1'b1;
                  state_nx    = LOAD;
               end
            end
`ifdef SPI_TIMEOUT_EN
            else if (wdog == '0) begin
               ss_n_nx         = '1;
               grant_nx        = '0;
               txn_err_nx[idx] = 1'b1;
               tmr_nx          = GAP_LD;
               state_nx        = GAP;
            end else begin
               wdog_nx = wdog - 1'b1;
            end
`endif
         end
         HOLD: begin
            if (tmr == '0) begin
               ss_n_nx          = '1;
               grant_nx         = '0;
               txn_done_nx[idx] = 1'b1;
               tmr_nx           = GAP_LD;
               state_nx         = GAP;
            end else begin
               tmr_nx = tmr - 1'b1;
            end
         end
         GAP: begin
            if (tmr == '0) begin
               ptr_nx   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
               state_nx = IDLE;
            end else begin
               tmr_nx = tmr - 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         ptr      <= '0;
         idx      <= '0;
         byte_cnt <= '0;
         tmr      <= '0;
         grant    <= '0;
         ss_n     <= '1;
         spi_dvsr <= '0;
         spi_cpol <= 1'b0;
         spi_cpha <= 1'b0;
         rx_data  <= '0;
         rx_valid <= '0;
         txn_done <= '0;
      end else begin
         state    <= state_nx;
         ptr      <= ptr_nx;
         idx      <= idx_nx;
         byte_cnt <= byte_cnt_nx;
         tmr      <= tmr_nx;
         grant    <= grant_nx;
         ss_n     <= ss_n_nx;
         spi_dvsr <= spi_dvsr_nx;
         spi_cpol <= spi_cpol_nx;
         spi_cpha <= spi_cpha_nx;
         rx_data  <= rx_data_nx;
         rx_valid <= rx_valid_nx;
         txn_done <= txn_done_nx;
      end
   end

`ifdef SPI_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (!reset) begin
         wdog    <= '0;
         txn_err <= '0;
      end else begin
         wdog    <= wdog_nx;
         txn_err <= txn_err_nx;
      end
   end
`else
   assign txn_err = '0;
`endif

endmodule

// File: tb/tb_spi_txn_arbiter.sv
// Directed bench for spi_txn_arbiter with a 3-cycle loopback SPI engine model.
// Build with SPI_TIMEOUT_EN to exercise the watchdog abort path as well.
module tb_spi_txn_arbiter;

   localparam int NREQ  = 2;
   localparam int LEN_W = 4;

   logic                  clk = 1'b0;
   logic                  reset = 1'b0;
   logic [NREQ-1:0]       req = '0;
   logic [NREQ*LEN_W-1:0] req_len = '0;
   logic [NREQ-1:0]       req_cpol = '0;
   logic [NREQ-1:0]       req_cpha = '0;
   logic [NREQ*16-1:0]    req_dvsr = '0;
   logic [NREQ*8-1:0]     tx_data;
   logic [NREQ-1:0]       grant, tx_rd, rx_valid, txn_done, txn_err, ss_n;
   logic [7:0]            rx_data, spi_din, spi_dout;
   logic [15:0]           spi_dvsr;
   logic                  spi_start, spi_cpol, spi_cpha;
   logic                  spi_ready = 1'b1;
   logic                  spi_done_tick = 1'b0;

   spi_txn_arbiter #(
      .NREQ(NREQ), .LEN_W(LEN_W), .SS_SETUP(4), .SS_HOLD(4), .SS_GAP(2), .TIMEOUT_CYC(64)
   ) dut (
      .clk(clk), .reset(reset), .req(req), .req_len(req_len), .req_cpol(req_cpol),
      .req_cpha(req_cpha), .req_dvsr(req_dvsr), .tx_data(tx_data), .grant(grant),
      .tx_rd(tx_rd), .rx_data(rx_data), .rx_valid(rx_valid), .txn_done(txn_done),
      .txn_err(txn_err), .ss_n(ss_n), .spi_start(spi_start), .spi_din(spi_din),
      .spi_dvsr(spi_dvsr), .spi_cpol(spi_cpol), .spi_cpha(spi_cpha),
      .spi_ready(spi_ready), .spi_done_tick(spi_done_tick), .spi_dout(spi_dout)
   );

   always #5 clk = ~clk;

   // engine model: byte finishes 3 cycles after start, echoes din; eng_hang freezes it
   logic [7:0] eng_byte = '0;
   int         eng_cnt = 0;
   logic       eng_hang = 1'b0;
   initial spi_dout = '0;

   always @(posedge clk) begin
      spi_done_tick <= 1'b0;
      if (!reset) begin
         spi_ready <= 1'b1;
         eng_cnt   <= 0;
      end else if (spi_ready) begin
         if (spi_start) begin
            spi_ready <= 1'b0;
            eng_byte  <= spi_din;
            eng_cnt   <= 3;
         end
      end else if (!eng_hang) begin
         if (eng_cnt == 1) begin
            spi_done_tick <= 1'b1;
            spi_dout      <= eng_byte;
            spi_ready     <= 1'b1;
         end
         eng_cnt <= eng_cnt - 1;
      end
   end

   logic [7:0] tx_bytes [NREQ][16];
   int         tx_pos [NREQ] = '{default: 0};

   always @(posedge clk)
      for (int i = 0; i < NREQ; i++)
         if (!reset) tx_pos[i] <= 0;
         else if (tx_rd[i]) tx_pos[i] <= tx_pos[i] + 1;

   always_comb begin
      tx_data = '0;
      for (int i = 0; i < NREQ; i++) tx_data[i*8 +: 8] = tx_bytes[i][tx_pos[i] % 16];
   end

   // monitor, sampled on the falling edge
   int          cyc = 0, n_start = 0, t_start = 0, n_both_low = 0;
   int          hi_run = 0, min_gap = 1000;
   logic        seen_burst = 1'b0;
   int          n_txrd[NREQ] = '{default: 0};
   int          n_rxv[NREQ] = '{default: 0};
   int          n_done[NREQ] = '{default: 0};
   int          n_err[NREQ] = '{default: 0};
   int          n_ss_rise[NREQ] = '{default: 0};
   int          t_fall[NREQ] = '{default: 0};
   int          t_rxv[NREQ] = '{default: 0};
   int          t_done[NREQ] = '{default: 0};
   int          t_err[NREQ] = '{default: 0};
   logic        ss_at_err[NREQ] = '{default: 1'b0};
   logic [17:0] cfg_obs[NREQ] = '{default: '0};
   logic [NREQ-1:0] grant_at_err = '0;
   logic [NREQ-1:0] prev_grant = '0, prev_ss = '1;
   logic [7:0]  last_rx0 = '0;
   logic [7:0]  rxq0[$];
   logic [NREQ-1:0] glog[$];

   always @(negedge clk) begin
      cyc        <= cyc + 1;
      prev_grant <= grant;
      prev_ss    <= ss_n;
      if (spi_start) begin
         n_start <= n_start + 1;
         t_start <= cyc;
      end
      for (int i = 0; i < NREQ; i++) begin
         if (spi_start && grant[i]) cfg_obs[i] <= {spi_cpol, spi_cpha, spi_dvsr};
         if (tx_rd[i]) n_txrd[i] <= n_txrd[i] + 1;
         if (rx_valid[i]) begin
            n_rxv[i] <= n_rxv[i] + 1;
            t_rxv[i] <= cyc;
         end
         if (txn_done[i]) begin
            n_done[i] <= n_done[i] + 1;
            t_done[i] <= cyc;
         end
         if (txn_err[i]) begin
            n_err[i]     <= n_err[i] + 1;
            t_err[i]     <= cyc;
            ss_at_err[i] <= ss_n[i];
            grant_at_err <= grant;
         end
         if (ss_n[i] && !prev_ss[i]) n_ss_rise[i] <= n_ss_rise[i] + 1;
         if (!ss_n[i] && prev_ss[i]) t_fall[i] <= cyc;
      end
      if (rx_valid[0]) begin
         last_rx0 <= rx_data;
         rxq0.push_back(rx_data);
      end
      if (ss_n == '1) begin
         hi_run <= hi_run + 1;
      end else begin
         if (prev_ss == '1 && seen_burst && hi_run < min_gap) min_gap <= hi_run;
         hi_run     <= 0;
         seen_burst <= 1'b1;
      end
      if (ss_n == '0) n_both_low <= n_both_low + 1;
      if (grant != prev_grant && grant != '0) glog.push_back(grant);
   end

   int n_chk = 0, n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
   endtask

   task automatic wait_grant(input logic [NREQ-1:0] g, input string tag);
      for (int k = 0; k < 300 && grant != g; k++) tick();
      chk(tag, grant, g);
   endtask

   task automatic wait_done(input int r, input int base, input string tag);
      for (int k = 0; k < 400 && n_done[r] == base; k++) tick();
      chk(tag, n_done[r] - base, 1);
   endtask

   int s_start, s_done0, s_done1, s_rxv0, s_rxv1, s_txrd0, s_rise0, s_rxq, s_gl, s_both, s_err0, base;
   logic [7:0] exp_b[4] = '{8'h11, 8'h22, 8'h33, 8'h44};

   initial begin
      for (int i = 0; i < NREQ; i++)
         for (int j = 0; j < 16; j++) tx_bytes[i][j] = 8'h00;
      tick();
      tick();
      chk("rst_ss_n", ss_n, 2'b11);
      chk("rst_grant", grant, 2'b00);
      chk("rst_spi_start", spi_start, 1'b0);
      chk("rst_spi_dvsr", spi_dvsr, 16'h0000);
      chk("rst_cpol_cpha", {spi_cpol, spi_cpha}, 2'b00);
      chk("rst_rx_data", rx_data, 8'h00);
      chk("rst_pulses", {rx_valid, txn_done, txn_err, tx_rd}, 8'h00);
      reset = 1'b1;
      tick();

      // single byte burst
      tx_bytes[0][tx_pos[0] % 16] = 8'hA5;
      req_len = '0;
      s_start = n_start;
      s_done0 = n_done[0];
      req = 2'b01;
      wait_grant(2'b01, "t1_grant");
      req = 2'b00;
      wait_done(0, s_done0, "t1_done");
      chk("t1_start_cnt", n_start - s_start, 1);
      chk("t1_setup_cyc", t_start - t_fall[0], 4);
      chk("t1_rx_data", last_rx0, 8'hA5);
      chk("t1_hold_cyc", t_done[0] - t_rxv[0], 4);
      chk("t1_ss_released", ss_n, 2'b11);

      // four byte burst
      base = tx_pos[0];
      for (int k = 0; k < 4; k++) tx_bytes[0][(base + k) % 16] = exp_b[k];
      req_len = 8'h03;
      s_start = n_start;
      s_done0 = n_done[0];
      s_rxv0  = n_rxv[0];
      s_txrd0 = n_txrd[0];
      s_rise0 = n_ss_rise[0];
      s_rxq   = rxq0.size();
      req = 2'b01;
      wait_grant(2'b01, "t2_grant");
      req = 2'b00;
      wait_done(0, s_done0, "t2_done");
      chk("t2_start_cnt", n_start - s_start, 4);
      chk("t2_txrd_cnt", n_txrd[0] - s_txrd0, 4);
      chk("t2_rxv_cnt", n_rxv[0] - s_rxv0, 4);
      chk("t2_ss_rises", n_ss_rise[0] - s_rise0, 1);
      for (int k = 0; k < 4; k++) chk($sformatf("t2_rx_byte%0d", k), rxq0[s_rxq + k], exp_b[k]);
      repeat (10) tick();
      chk("t2_single_done", n_done[0] - s_done0, 1);

      // both requesting continuously after reset
      do_reset();
      req_len = '0;
      s_gl    = glog.size();
      s_both  = n_both_low;
      s_done0 = n_done[0] + n_done[1];
      req = 2'b11;
      for (int k = 0; k < 600 && (n_done[0] + n_done[1] - s_done0) < 4; k++) tick();
      req = 2'b00;
      chk("t3_four_bursts", n_done[0] + n_done[1] - s_done0, 4);
      repeat (10) tick();
      chk("t3_grant0", glog[s_gl], 2'b01);
      chk("t3_grant1", glog[s_gl + 1], 2'b10);
      chk("t3_grant2", glog[s_gl + 2], 2'b01);
      chk("t3_grant3", glog[s_gl + 3], 2'b10);
      chk("t3_both_low", n_both_low - s_both, 0);
      chk("t3_min_gap", min_gap, 3);

      // per-requester config, sampled only at grant
      req_cpol = 2'b10;
      req_cpha = 2'b10;
      req_dvsr = {16'd4, 16'd9};
      s_done1  = n_done[1];
      req = 2'b11;
      wait_grant(2'b10, "t4_grant1");
      chk("t4_live_cfg1", {spi_cpol, spi_cpha, spi_dvsr}, 18'h30004);
      req_dvsr[31:16] = 16'hFFFF;
      req_cpol[1] = 1'b0;
      req = 2'b00;
      wait_done(1, s_done1, "t4_done1");
      chk("t4_cfg0", cfg_obs[0], 18'h00009);
      chk("t4_cfg1", cfg_obs[1], 18'h30004);
      req_cpol = '0;
      req_cpha = '0;
      req_dvsr = '0;

      // reset during byte 2 of 4
      base = tx_pos[0];
      for (int k = 0; k < 4; k++) tx_bytes[0][(base + k) % 16] = exp_b[k];
      req_len = 8'h03;
      s_done0 = n_done[0];
      s_err0  = n_err[0];
      req = 2'b01;
      wait_grant(2'b01, "t5_grant");
      req = 2'b00;
      s_start = n_start;
      for (int k = 0; k < 200 && (n_start - s_start) < 2; k++) tick();
      chk("t5_second_byte", n_start - s_start, 2);
      tick();
      reset = 1'b0;
      tick();
      chk("t5_ss_n", ss_n, 2'b11);
      chk("t5_grant", grant, 2'b00);
      chk("t5_spi_start", spi_start, 1'b0);
      tick();
      reset = 1'b1;
      repeat (20) tick();
      chk("t5_no_done", n_done[0] - s_done0, 0);
      chk("t5_no_err", n_err[0] - s_err0, 0);
      tx_bytes[0][tx_pos[0] % 16] = 8'h5C;
      req_len = '0;
      s_start = n_start;
      req = 2'b01;
      wait_grant(2'b01, "t5_regrant");
      req = 2'b00;
      wait_done(0, s_done0, "t5_clean_done");
      chk("t5_clean_start", n_start - s_start, 1);
      chk("t5_clean_rx", last_rx0, 8'h5C);

`ifdef SPI_TIMEOUT_EN
      // engine never ticks: watchdog aborts requester 0, requester 1 follows
      do_reset();
      req_len  = '0;
      s_done0  = n_done[0];
      s_done1  = n_done[1];
      s_err0   = n_err[0];
      s_rxv0   = n_rxv[0];
      s_rxv1   = n_rxv[1];
      eng_hang = 1'b1;
      req = 2'b11;
      for (int k = 0; k < 400 && n_err[0] == s_err0; k++) tick();
      chk("t6_err_cnt", n_err[0] - s_err0, 1);
      chk("t6_err_cyc", t_err[0] - t_start, 65);
      chk("t6_ss_at_err", ss_at_err[0], 1'b1);
      chk("t6_grant_at_err", grant_at_err, 2'b00);
      chk("t6_no_done", n_done[0] - s_done0, 0);
      eng_hang = 1'b0;
      wait_grant(2'b10, "t6_next_grant");
      req = 2'b00;
      wait_done(1, s_done1, "t6_done1");
      chk("t6_rxv0", n_rxv[0] - s_rxv0, 0);
      chk("t6_rxv1", n_rxv[1] - s_rxv1, 1);
`else
      chk("no_txn_err", n_err[0] + n_err[1], 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL global_timeout: simulation did not finish, %0d/%0d", n_pass, n_chk);
      $fatal(1);
   end

endmodule
